dense_layer_fp_hs: RTL and testbench
====================================

Name: dense_layer_fp_hs

Overview:
Fixed-point dense (fully connected) layer with valid/ready handshakes on both sides. Each output channel gets bias add, round-half-up right shift and signed saturation. Input vector arrives as NUM_CYC beats of INPUT_SIZE elements and produces OUTPUT_SIZE results. Sits between feature-extraction stages and the classifier head, where downstream back-pressure must stall the layer without losing data.

Parameters:
INPUT_SIZE, 4, elements per input beat
NUM_CYC, 512, beats per input vector (>=1)
OUTPUT_SIZE, 128, output channels
BW_IN, 16, input element width
BW_W, 16, weight width (signed)
BW_B, 32, bias width (signed, accumulator scale)
BW_OUT, 16, output width (signed)
R_SHIFT, 0, arithmetic right shift applied after bias add
USE_UNSIGNED_DATA, 0, 1 = data_in zero-extended, 0 = signed

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
vld_in  in  1  input beat valid
rdy_in  out  1  layer can accept beat
w_vec  in  OUTPUT_SIZE*INPUT_SIZE*BW_W  weights for current beat, channel i at [i*INPUT_SIZE +: INPUT_SIZE]
data_in  in  INPUT_SIZE*BW_IN  input elements
b_vec  in  OUTPUT_SIZE*BW_B  biases, sampled with the last beat only
vld_out  out  1  result valid
rdy_out  in  1  downstream accepts result
data_out  out  OUTPUT_SIZE*BW_OUT  results
sat_out  out  1  valid with vld_out: any channel saturated

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high. All state resets on rst assertion without waiting for a clock edge.
- Beat accepted iff vld_in && rdy_in. Weights, data and (last beat) bias are valid only in the accept cycle.
- Beat counter cntr runs 0..NUM_CYC-1 and advances on accept only. It wraps to 0 after the last beat.
- Accumulator width BW_ACC = BW_IN+BW_W+1+clog2(NUM_CYC*INPUT_SIZE).
- Pipeline for a beat accepted at cycle t:
  - t+1: products registered.
  - t+2: adder-tree sum added into accumulator. The first beat of a vector loads rather than adds, via a first flag carried with the beat.
- Last beat accepted at t:
  - t+2: acc + sign-extended bias is final.
  - t+3: data_out and sat_out registered, vld_out=1.
- Post-process per channel:
  - Add 2^(R_SHIFT-1) when R_SHIFT>0.
  - Arithmetic shift right by R_SHIFT.
  - Saturate to [-2^(BW_OUT-1), 2^(BW_OUT-1)-1]. Any clamp sets sat_out.
- Output hold: vld_out, data_out and sat_out are held until vld_out && rdy_out. vld_out clears on the cycle after the handshake unless a new result lands that cycle.
- Flow control: an inflight flag is set on accepting the last beat and cleared when its result lands. rdy_in = !(cntr==NUM_CYC-1 && (inflight || (vld_out && !rdy_out))).
  - Non-last beats are never stalled.
  - A result can never overwrite an unconsumed one.
  - Result landing and consumption in the same cycle: the new result wins and vld_out stays 1.
- NUM_CYC=1: every beat is a last beat. Sustained throughput is 1 vector per 3 cycles.
- Reset values: rdy_in=1 after reset (combinational from reset state), vld_out=0, sat_out=0, data_out=0, cntr=0, inflight=0, pipeline valids=0. Accumulators need no reset.
- Reset mid-vector: the partial vector is discarded and the next accepted beat is treated as beat 0.

Optional Feature:
DENSE_LAYER_FP_HS_RELU_EN defined: after saturation, negative channel results are forced to 0. sat_out is unaffected by the ReLU clamp. Undefined: results pass through signed. Latency is identical in both cases.

Decomposition:
- Package dense_fp_pkg:
  - BW_ACC computation function.
  - Round/shift/saturate function (acc, R_SHIFT, BW_OUT) returning value and sat flag.
  - Signed/unsigned extend function.
- Sub-module mac_lane_fp: one channel holding products, adder tree, accumulator, bias add and post-process. Generated OUTPUT_SIZE times.
- Top level holds the counter, flow control, valid pipeline and output hold register.

Test Plan:
- INPUT_SIZE=2, NUM_CYC=2, OUTPUT_SIZE=2, R_SHIFT=0, all weights 1, bias 0; beats {1,2},{3,4} back-to-back with rdy_out=1 -> both channels data_out=10, vld_out exactly 3 cycles after the last-beat accept, sat_out=0.
- Same config, rdy_out=0, two vectors streamed -> first result held, rdy_in=0 on the second vector's last beat until rdy_out=1. Results then arrive in order (10, then 10 with bias 5 -> 15); none lost or duplicated.
- BW_OUT=8, weights 100, data {100,100} -> data_out=127, sat_out=1. Weights -100 -> data_out=-128, sat_out=1.
- R_SHIFT=2: accumulator+bias of 6 -> 2, 5 -> 1, -6 -> -1, -7 -> -2.
- Assert rst for 1 cycle after the first beat -> vld_out=0 and rdy_in=1 immediately. The following full vector {1,2},{3,4} still yields 10.
- Result -5 -> data_out=0 with DENSE_LAYER_FP_HS_RELU_EN, -5 without. Latency unchanged.

Source files
------------

// File: rtl/dense_fp_pkg.sv
// Shared widths and arithmetic helpers for the fixed-point dense layer.
package dense_fp_pkg;

  localparam int unsigned MAXW = 128;

  typedef logic signed [MAXW-1:0] wide_t;

  typedef struct packed {
    wide_t val;
    logic  sat;
  } rss_t;

  function automatic int unsigned bw_acc_calc(input int unsigned bw_in,
                                              input int unsigned bw_w,
                                              input int unsigned n_terms);
    return bw_in + bw_w + 1 + $clog2(n_terms);
  endfunction

  // Left-justify then shift back: arithmetic for signed, logical for unsigned.
  function automatic wide_t ext(input logic [MAXW-1:0] x,
                                input int unsigned     bw,
                                input logic            is_unsigned);
    wide_t t;
    t = x << (MAXW - bw);
    if (is_unsigned)
      return t >> (MAXW - bw);
    else
      return t >>> (MAXW - bw);
  endfunction

  function automatic rss_t round_shift_sat(input wide_t       acc,
                                           input int unsigned r_shift,
                                           input int unsigned bw_out);
    wide_t v;
    wide_t hi;
    wide_t lo;
    wide_t one;
    rss_t  o;
    one = wide_t'(1);
    v   = acc;
    if (r_shift > 0)
      v = v + (one <<< (r_shift - 1));
    v   = v >>> r_shift;
    hi  = (one <<< (bw_out - 1)) - one;
    lo  = -hi - one;
    o.val = v;
    o.sat = 1'b0;
    if (v > hi) begin
      o.val = hi;
      o.sat = 1'b1;
    end else if (v < lo) begin
      o.val = lo;
      o.sat = 1'b1;
    end
    return o;
  endfunction

endpackage

// File: rtl/dense_layer_fp_hs_if.sv
// Input-beat and result handshake bundle for dense_layer_fp_hs.
interface dense_layer_fp_hs_if #(
  parameter int unsigned INPUT_SIZE  = 4,
  parameter int unsigned OUTPUT_SIZE = 128,
  parameter int unsigned BW_IN       = 16,
  parameter int unsigned BW_W        = 16,
  parameter int unsigned BW_B        = 32,
  parameter int unsigned BW_OUT      = 16
);
  logic                                  vld_in;
  logic                                  rdy_in;
  logic [OUTPUT_SIZE*INPUT_SIZE*BW_W-1:0] w_vec;
  logic [INPUT_SIZE*BW_IN-1:0]           data_in;
  logic [OUTPUT_SIZE*BW_B-1:0]           b_vec;
  logic                                  vld_out;
  logic                                  rdy_out;
  logic [OUTPUT_SIZE*BW_OUT-1:0]         data_out;
  logic                                  sat_out;

  modport master (
    output vld_in, w_vec, data_in, b_vec, rdy_out,
    input  rdy_in, vld_out, data_out, sat_out
  );

  modport slave (
    input  vld_in, w_vec, data_in, b_vec, rdy_out,
    output rdy_in, vld_out, data_out, sat_out
  );
endinterface

// File: rtl/mac_lane_fp.sv
// One output channel: products, adder tree, accumulator, bias and post-process.
// DENSE_LAYER_FP_HS_RELU_EN clamps negative saturated results to zero.
module mac_lane_fp
  import dense_fp_pkg::*;
#(
  parameter int unsigned INPUT_SIZE        = 4,
  parameter int unsigned NUM_CYC           = 512,
  parameter int unsigned BW_IN             = 16,
  parameter int unsigned BW_W              = 16,
  parameter int unsigned BW_B              = 32,
  parameter int unsigned BW_OUT            = 16,
  parameter int unsigned R_SHIFT           = 0,
  parameter int unsigned USE_UNSIGNED_DATA = 0
) (
  input  logic                        clk,
  input  logic                        beat_acc,
  input  logic                        last_acc,
  input  logic                        sum_en,
  input  logic                        sum_first,
  input  logic [INPUT_SIZE*BW_W-1:0]  w_ch,
  input  logic [INPUT_SIZE*BW_IN-1:0] data_in,
  input  logic [BW_B-1:0]             bias,
  output logic [BW_OUT-1:0]           res,
  output logic                        sat
);

  localparam int unsigned BW_ACC = bw_acc_calc(BW_IN, BW_W, NUM_CYC * INPUT_SIZE);
  localparam int unsigned BW_P   = BW_IN + BW_W + 1;
  localparam logic        UNS    = (USE_UNSIGNED_DATA != 0);

  logic signed [BW_P-1:0]   prod_d [INPUT_SIZE];
  logic signed [BW_P-1:0]   prod_q [INPUT_SIZE];
  logic signed [BW_ACC-1:0] tree_sum;
  logic signed [BW_ACC-1:0] acc_q;
  logic signed [BW_B-1:0]   bias_q;
  wide_t                    fin;
  rss_t                     pp;
  logic                     unused_pp_hi;

  always_comb begin
    prod_d = '{default: '0};
    for (int unsigned j = 0; j < INPUT_SIZE; j++)
      prod_d[j] = BW_P'(ext(MAXW'(data_in[j*BW_IN +: BW_IN]), BW_IN, UNS))
                * BW_P'($signed(w_ch[j*BW_W +: BW_W]));
  end

  always_comb begin
    tree_sum = '0;
    for (int unsigned j = 0; j < INPUT_SIZE; j++)
      tree_sum = tree_sum + BW_ACC'(prod_q[j]);
  end

  // Datapath registers carry no reset; the valid pipeline in the top qualifies them.
  always_ff @(posedge clk) begin
    if (beat_acc)
      for (int unsigned j = 0; j < INPUT_SIZE; j++)
        prod_q[j] <= prod_d[j];
    if (last_acc)
      bias_q <= $signed(bias);
    if (sum_en)
      acc_q <= sum_first ? tree_sum : acc_q + tree_sum;
  end

  always_comb begin
    fin = wide_t'(acc_q) + wide_t'(bias_q);
    pp  = round_shift_sat(fin, R_SHIFT, BW_OUT);
    sat = pp.sat;
`ifdef DENSE_LAYER_FP_HS_RELU_EN
    res = (pp.val < 0) ? '0 : BW_OUT'(pp.val);
`else
    res = BW_OUT'(pp.val);
`endif
  end

  assign unused_pp_hi = ^pp.val[MAXW-1:BW_OUT];

endmodule

// File: rtl/dense_layer_fp_hs.sv
// Fixed-point dense layer: beat counter, flow control, valid pipeline and
// output hold register around OUTPUT_SIZE mac_lane_fp channels.
module dense_layer_fp_hs
  import dense_fp_pkg::*;
#(
  parameter int unsigned INPUT_SIZE        = 4,
  parameter int unsigned NUM_CYC           = 512,
  parameter int unsigned OUTPUT_SIZE       = 128,
  parameter int unsigned BW_IN             = 16,
  parameter int unsigned BW_W              = 16,
  parameter int unsigned BW_B              = 32,
  parameter int unsigned BW_OUT            = 16,
  parameter int unsigned R_SHIFT           = 0,
  parameter int unsigned USE_UNSIGNED_DATA = 0
) (
  input logic               clk,
  input logic               rst,
  dense_layer_fp_hs_if.slave bus
);

  localparam int unsigned CW = (NUM_CYC > 1) ? $clog2(NUM_CYC) : 1;

  logic [CW-1:0]                 cntr;
  logic                          last_beat;
  logic                          accept;
  logic                          inflight;
  logic                          s1_vld;
  logic                          s1_first;
  logic                          s1_last;
  logic                          s2_last;
  logic [OUTPUT_SIZE*BW_OUT-1:0] res_all;
  logic [OUTPUT_SIZE-1:0]        sat_all;

  assign last_beat  = (cntr == CW'(NUM_CYC - 1));
  // Only a last beat can be stalled: it must wait until the previous result
  // has landed and the output register is free or being drained this cycle.
  assign bus.rdy_in = !(last_beat && (inflight || (bus.vld_out && !bus.rdy_out)));
  assign accept     = bus.vld_in && bus.rdy_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntr         <= '0;
      inflight     <= 1'b0;
      s1_vld       <= 1'b0;
      s1_first     <= 1'b0;
      s1_last      <= 1'b0;
      s2_last      <= 1'b0;
      bus.vld_out  <= 1'b0;
      bus.sat_out  <= 1'b0;
      bus.data_out <= '0;
    end else begin
      s1_vld   <= accept;
      s1_first <= accept && (cntr == '0);
      s1_last  <= accept && last_beat;
      s2_last  <= s1_vld && s1_last;

      if (accept)
        cntr <= last_beat ? '0 : cntr + 1'b1;

      if (accept && last_beat)
        inflight <= 1'b1;
      else if (s2_last)
        inflight <= 1'b0;

      if (s2_last) begin
        bus.vld_out  <= 1'b1;
        bus.data_out <= res_all;
        bus.sat_out  <= |sat_all;
      end else if (bus.vld_out && bus.rdy_out) begin
        bus.vld_out <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < OUTPUT_SIZE; i++) begin : g_lane
    mac_lane_fp #(
      .INPUT_SIZE       (INPUT_SIZE),
      .NUM_CYC          (NUM_CYC),
      .BW_IN            (BW_IN),
      .BW_W             (BW_W),
      .BW_B             (BW_B),
      .BW_OUT           (BW_OUT),
      .R_SHIFT          (R_SHIFT),
      .USE_UNSIGNED_DATA(USE_UNSIGNED_DATA)
    ) u_lane (
      .clk      (clk),
      .beat_acc (accept),
      .last_acc (accept && last_beat),
      .sum_en   (s1_vld),
      .sum_first(s1_first),
      .w_ch     (bus.w_vec[i*INPUT_SIZE*BW_W +: INPUT_SIZE*BW_W]),
      .data_in  (bus.data_in),
      .bias     (bus.b_vec[i*BW_B +: BW_B]),
      .res      (res_all[i*BW_OUT +: BW_OUT]),
      .sat      (sat_all[i])
    );
  end

endmodule

// File: tb/tb_dense_layer_fp_hs.sv
// Directed bench for dense_layer_fp_hs: three small configurations sharing one clock.
module tb_dense_layer_fp_hs;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // A: 2 beats x 2 elements, 2 channels, 16-bit out
  dense_layer_fp_hs_if #(.INPUT_SIZE(2), .OUTPUT_SIZE(2), .BW_IN(16), .BW_W(16),
                         .BW_B(32), .BW_OUT(16)) a_if ();
  dense_layer_fp_hs #(.INPUT_SIZE(2), .NUM_CYC(2), .OUTPUT_SIZE(2), .BW_IN(16),
                      .BW_W(16), .BW_B(32), .BW_OUT(16), .R_SHIFT(0),
                      .USE_UNSIGNED_DATA(0))
    u_a (.clk(clk), .rst(rst), .bus(a_if.slave));

  // B: single beat, 8-bit out for saturation
  dense_layer_fp_hs_if #(.INPUT_SIZE(2), .OUTPUT_SIZE(2), .BW_IN(16), .BW_W(16),
                         .BW_B(32), .BW_OUT(8)) b_if ();
  dense_layer_fp_hs #(.INPUT_SIZE(2), .NUM_CYC(1), .OUTPUT_SIZE(2), .BW_IN(16),
                      .BW_W(16), .BW_B(32), .BW_OUT(8), .R_SHIFT(0),
                      .USE_UNSIGNED_DATA(0))
    u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  // C: single beat, 4 channels, R_SHIFT=2 rounding
  dense_layer_fp_hs_if #(.INPUT_SIZE(2), .OUTPUT_SIZE(4), .BW_IN(16), .BW_W(16),
                         .BW_B(32), .BW_OUT(16)) c_if ();
  dense_layer_fp_hs #(.INPUT_SIZE(2), .NUM_CYC(1), .OUTPUT_SIZE(4), .BW_IN(16),
                      .BW_W(16), .BW_B(32), .BW_OUT(16), .R_SHIFT(2),
                      .USE_UNSIGNED_DATA(0))
    u_c (.clk(clk), .rst(rst), .bus(c_if.slave));

  function automatic int relu(input int v);
`ifdef DENSE_LAYER_FP_HS_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic a_drive(input logic v, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [31:0] b);
    a_if.vld_in  = v;
    a_if.data_in = {d1, d0};
    a_if.b_vec   = {b, b};
  endtask

  task automatic a_result(input string tag, input int exp_val);
    chk({tag, "_vld"}, a_if.vld_out, 1);
    chk({tag, "_ch0"}, $signed(a_if.data_out[15:0]), exp_val);
    chk({tag, "_ch1"}, $signed(a_if.data_out[31:16]), exp_val);
    chk({tag, "_sat"}, a_if.sat_out, 0);
  endtask

  initial begin
    rst = 1'b1;
    a_if.w_vec   = {4{16'd1}};
    a_if.rdy_out = 1'b1;
    a_drive(0, 0, 0, 0);
    b_if.vld_in  = 1'b0;
    b_if.w_vec   = {16'hFF9C, 16'hFF9C, 16'd100, 16'd100};
    b_if.data_in = {16'd100, 16'd100};
    b_if.b_vec   = '0;
    b_if.rdy_out = 1'b1;
    c_if.vld_in  = 1'b0;
    c_if.w_vec   = {8{16'd1}};
    c_if.data_in = {16'd2, 16'd1};
    c_if.b_vec   = {32'hFFFF_FFF6, 32'hFFFF_FFF7, 32'd2, 32'd3};
    c_if.rdy_out = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_vld_out", a_if.vld_out, 0);
    chk("rst_rdy_in", a_if.rdy_in, 1);
    chk("rst_sat_out", a_if.sat_out, 0);
    chk("rst_data_out", $signed(a_if.data_out), 0);
    rst = 1'b0;

    // Basic vector {1,2},{3,4}, weights 1, bias 0
    @(negedge clk); a_drive(1, 1, 2, 0);
    chk("t1_rdy_b0", a_if.rdy_in, 1);
    @(negedge clk); a_drive(1, 3, 4, 0);
    chk("t1_rdy_b1", a_if.rdy_in, 1);
    @(negedge clk); a_drive(0, 0, 0, 0);
    chk("t1_lat1", a_if.vld_out, 0);
    @(negedge clk);
    chk("t1_lat2", a_if.vld_out, 0);
    @(negedge clk);
    a_result("t1", 10);
    @(negedge clk);
    chk("t1_drained", a_if.vld_out, 0);

    // Back-pressure: two vectors streamed with rdy_out low
    @(negedge clk); a_if.rdy_out = 1'b0; a_drive(1, 1, 2, 0);
    @(negedge clk); a_drive(1, 3, 4, 0);
    chk("t2_rdy_v1last", a_if.rdy_in, 1);
    @(negedge clk); a_drive(1, 1, 2, 0);
    chk("t2_rdy_v2b0", a_if.rdy_in, 1);
    @(negedge clk); a_drive(1, 3, 4, 5);
    #1 chk("t2_stall_inflight", a_if.rdy_in, 0);
    @(negedge clk);
    a_result("t2_r1", 10);
    chk("t2_stall_held", a_if.rdy_in, 0);
    @(negedge clk);
    a_result("t2_r1_hold", 10);
    chk("t2_stall_held2", a_if.rdy_in, 0);
    a_if.rdy_out = 1'b1;
    #1 chk("t2_rdy_release", a_if.rdy_in, 1);
    @(negedge clk); a_drive(0, 0, 0, 0);
    chk("t2_gap1", a_if.vld_out, 0);
    @(negedge clk);
    chk("t2_gap2", a_if.vld_out, 0);
    @(negedge clk);
    a_result("t2_r2", 15);
    @(negedge clk);
    chk("t2_drained", a_if.vld_out, 0);

    // Reset with a pending result and a partial vector
    @(negedge clk); a_if.rdy_out = 1'b0; a_drive(1, 1, 2, 0);
    @(negedge clk); a_drive(1, 3, 4, 0);
    @(negedge clk); a_drive(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    a_result("t3_pending", 10);
    a_drive(1, 1, 2, 0);
    @(negedge clk); a_drive(0, 0, 0, 0); rst = 1'b1;
    #1;
    chk("t3_rst_vld", a_if.vld_out, 0);
    chk("t3_rst_rdy", a_if.rdy_in, 1);
    chk("t3_rst_data", $signed(a_if.data_out), 0);
    @(negedge clk); rst = 1'b0; a_if.rdy_out = 1'b1;
    @(negedge clk); a_drive(1, 1, 2, 0);
    chk("t3_rdy_b0", a_if.rdy_in, 1);
    @(negedge clk); a_drive(1, 3, 4, 0);
    @(negedge clk); a_drive(0, 0, 0, 0);
    chk("t3_lat1", a_if.vld_out, 0);
    @(negedge clk);
    chk("t3_lat2", a_if.vld_out, 0);
    @(negedge clk);
    a_result("t3_after", 10);

    // Negative result (-5) with and without the ReLU build option
    @(negedge clk); a_drive(1, 1, 2, -15);
    @(negedge clk); a_drive(1, 3, 4, -15);
    @(negedge clk); a_drive(0, 0, 0, 0);
    chk("t4_lat1", a_if.vld_out, 0);
    @(negedge clk);
    chk("t4_lat2", a_if.vld_out, 0);
    @(negedge clk);
    a_result("t4_neg", relu(-5));

    // Saturation on B, NUM_CYC=1 cadence of one vector per 3 cycles
    @(negedge clk); b_if.vld_in = 1'b1;
    chk("t5_rdy0", b_if.rdy_in, 1);
    @(negedge clk);
    chk("t5_rdy1", b_if.rdy_in, 0);
    @(negedge clk);
    chk("t5_rdy2", b_if.rdy_in, 0);
    chk("t5_lat2", b_if.vld_out, 0);
    @(negedge clk);
    chk("t5_vld", b_if.vld_out, 1);
    chk("t5_pos_sat", $signed(b_if.data_out[7:0]), 127);
    chk("t5_neg_sat", $signed(b_if.data_out[15:8]), relu(-128));
    chk("t5_sat_flag", b_if.sat_out, 1);
    chk("t5_rdy3", b_if.rdy_in, 1);
    @(negedge clk); b_if.vld_in = 1'b0;
    chk("t5_drained", b_if.vld_out, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_vld2", b_if.vld_out, 1);
    chk("t5_pos_sat2", $signed(b_if.data_out[7:0]), 127);

    // Round-half-up shift on C: 6->2, 5->1, -6->-1, -7->-2
    @(negedge clk); c_if.vld_in = 1'b1;
    @(negedge clk); c_if.vld_in = 1'b0;
    @(negedge clk);
    chk("t6_lat2", c_if.vld_out, 0);
    @(negedge clk);
    chk("t6_vld", c_if.vld_out, 1);
    chk("t6_p6", $signed(c_if.data_out[15:0]), 2);
    chk("t6_p5", $signed(c_if.data_out[31:16]), 1);
    chk("t6_m6", $signed(c_if.data_out[47:32]), relu(-1));
    chk("t6_m7", $signed(c_if.data_out[63:48]), relu(-2));
    chk("t6_sat", c_if.sat_out, 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
